fp_issue_ctrl: RTL and testbench
================================

# fp_issue_ctrl

Single-issue dispatch controller for the FP execute stage. It sits between the FP decoder and two execution resources: a fully pipelined unit (add/sub/mul/FMA/compare/convert/move/classify) and an iterative div/sqrt unit. It enforces RAW/WAW hazards on FP registers with a 32-entry scoreboard. It also arbitrates the single shared writeback port between the two units.

## Interface

- PIPE_LAT, 4: fixed latency of the pipelined unit in cycles; legal range 2..8.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  decoded FP instruction present.
- in_ready_o  out  1  controller accepts the instruction this cycle.
- in_major_i  in  6  fp_major code from the decoder.
- in_rd_i, in_rs1_i, in_rs2_i, in_rs3_i  in  5 each  register indices.
- in_uses_frs1_i, in_uses_frs2_i, in_uses_frs3_i  in  1 each  FP source used.
- in_writes_frd_i, in_writes_xrd_i  in  1 each  destination is FP or integer register file.
- pipe_issue_o  out  1  one-cycle pulse: launch the operand bundle into the pipelined unit.
- div_start_o  out  1  one-cycle pulse: start the div/sqrt unit.
- div_done_i  in  1  one-cycle pulse from the div/sqrt unit: result valid.
- wb_valid_o  out  1  writeback this cycle.
- wb_rd_o  out  5  writeback register index.
- wb_to_x_o  out  1  1 = integer RF target, 0 = FP RF target.
- wb_sel_div_o  out  1  result mux select: 1 = div/sqrt result or hold register, 0 = pipe result.
- busy_o  out  1  any operation in flight or held.

## Operation

- **Routing.** in_major_i of 3 (div) or 6 (sqrt) goes to the div path. Every other major goes to the pipe path.
- **Scoreboard.**
  - sb[31:0] holds one pending-write bit per FP register.
  - The bit is set at accept when in_writes_frd_i=1.
  - The bit is cleared in the writeback cycle of that register when wb_to_x_o=0.
  - Integer-destination ops never touch sb.
- **Hazard.** Stall if any used source has its sb bit set, or if in_writes_frd_i=1 and sb[in_rd_i]=1.
  - The check uses the registered sb value. A bit being cleared in the current cycle still stalls; there is no bypass.
- **in_ready_o.** Equals ~hazard & (pipe path, or div FSM in IDLE). Forced to 0 while rst_i=1.
- **Accept.** Occurs when in_valid_i & in_ready_o.
  - Pipe path: pipe_issue_o=1 in the same cycle.
  - Div path: div_start_o=1 in the same cycle.
- **Pipe tracker.** A PIPE_LAT-deep shift register of {valid, rd, to_x}. Stage 0 is loaded on pipe accept; the last stage drives the writeback slot.
- **Div FSM.** States IDLE, RUN, HOLD; it latches {rd, to_x} at start.
  - IDLE→RUN on div accept.
  - RUN, div_done_i=1, pipe last stage empty: write back the div result that cycle, go to IDLE.
  - RUN, div_done_i=1, pipe last stage valid: the pipe wins. The external hold register captures the result, and the FSM goes to HOLD.
  - HOLD, pipe last stage empty: write back from HOLD, go to IDLE.
  - div_done_i outside RUN is ignored.
- **Writeback priority.** Pipe last stage first, then HOLD, then RUN+div_done_i. At most one writeback per cycle.
- **busy_o.** Set when any tracker stage is valid or the FSM is not IDLE.

## Timing

- **Reset.** sb=0, tracker cleared, FSM=IDLE. All outputs are 0 during reset and in the first cycle after it, except in_ready_o, which rises combinationally once rst_i=0.
- **Reset mid-operation.** Asserting rst_i discards all in-flight ops. A later div_done_i lands in IDLE and is ignored.
- **Pipe op.** Accepted at cycle T, it produces wb_valid_o at T+PIPE_LAT, with sb cleared at the T+PIPE_LAT edge. A dependent op is first acceptable at T+PIPE_LAT+1.
- **Div op.** Written back in the div_done_i cycle D if the slot is free, otherwise in the first cycle after D with no pipe writeback.
  - A new div op is accepted no earlier than the cycle after the FSM returns to IDLE.
- **Back-to-back.** Independent pipe ops issue one per cycle, and pipe ops continue to issue while the div FSM is in RUN or HOLD.
- **Outputs.** All outputs are combinational from registered state and the current inputs.

## Test plan

- **Reset.** Assert rst_i mid-stream with 2 pipe ops in flight -> all outputs 0 and sb=0. After release, no wb_valid_o pulse and busy_o=0.
- **RAW stall.** fadd f5 at T (PIPE_LAT=4), then fmul f6,f5,f1 presented at T+1 -> in_ready_o=0 for T+1..T+4, wb rd=5 at T+4, fmul accepted at T+5.
- **Throughput.** 6 independent fadds to f1..f6 on consecutive cycles -> 6 pipe_issue_o pulses, wb rd 1..6 on consecutive cycles from T+4.
- **Writeback collision.** fdiv f10 at T, fadd f11 at T+1, div_done_i at T+5 -> wb rd=11 (wb_sel_div_o=0) at T+5, rd=10 (wb_sel_div_o=1) at T+6, sb[10] clears at T+6.
- **Structural stall and integer destination.** A second fsqrt presented while the FSM is in RUN -> in_ready_o=0 until the cycle after the div writeback. feq x13 with rd=13 and a pending fadd f13 -> no WAW stall, and wb_to_x_o=1 at its slot.

Source files
------------

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: single-issue dispatch controller for the FP execute stage.
//
// Routes decoded FP ops either to a fixed-latency pipelined unit or to an
// iterative div/sqrt unit. It stalls on RAW/WAW hazards using a 32-entry
// pending-write scoreboard, and arbitrates the single shared writeback port.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   in_valid_i / in_ready_o      decoded instruction handshake
//   in_major_i                   fp_major code (3 = div, 6 = sqrt)
//   in_rd_i, in_rs1..3_i         register indices
//   in_uses_frs1..3_i            FP source operand used
//   in_writes_frd_i/xrd_i        destination in FP / integer register file
//   pipe_issue_o                 launch pulse into the pipelined unit
//   div_start_o, div_done_i      div/sqrt unit start / done pulses
//   wb_valid_o, wb_rd_o          writeback strobe and register index
//   wb_to_x_o                    1 = integer RF target
//   wb_sel_div_o                 1 = div/sqrt result or hold register
//   busy_o                       any operation in flight or held
module fp_issue_ctrl #(
   parameter int unsigned PIPE_LAT = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic [5:0] in_major_i,
   input  logic [4:0] in_rd_i,
   input  logic [4:0] in_rs1_i,
   input  logic [4:0] in_rs2_i,
   input  logic [4:0] in_rs3_i,
   input  logic       in_uses_frs1_i,
   input  logic       in_uses_frs2_i,
   input  logic       in_uses_frs3_i,
   input  logic       in_writes_frd_i,
   input  logic       in_writes_xrd_i,
   output logic       pipe_issue_o,
   output logic       div_start_o,
   input  logic       div_done_i,
   output logic       wb_valid_o,
   output logic [4:0] wb_rd_o,
   output logic       wb_to_x_o,
   output logic       wb_sel_div_o,
   output logic       busy_o
);

   localparam int unsigned LastStage = PIPE_LAT - 1;
   localparam logic [5:0]  MajorDiv  = 6'd3;
   localparam logic [5:0]  MajorSqrt = 6'd6;

   typedef enum logic [1:0] {StIdle, StRun, StHold} div_state_e;

   div_state_e div_state_q, div_state_d;

   logic [31:0]                sb_q, sb_d;
   logic [PIPE_LAT-1:0]        trk_valid_q;
   logic [PIPE_LAT-1:0][4:0]   trk_rd_q;
   logic [PIPE_LAT-1:0]        trk_to_x_q;
   logic [4:0]                 div_rd_q;
   logic                       div_to_x_q;

   logic is_div;
   logic hazard;
   logic accept;
   logic pipe_wb;

   assign is_div = (in_major_i == MajorDiv) || (in_major_i == MajorSqrt);

   // Registered scoreboard only: a bit being cleared this cycle still stalls.
   assign hazard = (in_uses_frs1_i  & sb_q[in_rs1_i]) |
                   (in_uses_frs2_i  & sb_q[in_rs2_i]) |
                   (in_uses_frs3_i  & sb_q[in_rs3_i]) |
                   (in_writes_frd_i & sb_q[in_rd_i]);

   assign in_ready_o   = ~rst_i & ~hazard & (~is_div | (div_state_q == StIdle));
   assign accept       = in_valid_i & in_ready_o;
   assign pipe_issue_o = accept & ~is_div;
   assign div_start_o  = accept & is_div;

   assign pipe_wb = trk_valid_q[LastStage];
   assign busy_o  = (|trk_valid_q) | (div_state_q != StIdle);

   // Writeback arbitration and div FSM. The pipe never stalls, so its last
   // stage always wins; a colliding div result parks in HOLD.
   always_comb begin
      div_state_d  = div_state_q;
      wb_valid_o   = 1'b0;
      wb_rd_o      = 5'd0;
      wb_to_x_o    = 1'b0;
      wb_sel_div_o = 1'b0;

      if (pipe_wb) begin
         wb_valid_o = 1'b1;
         wb_rd_o    = trk_rd_q[LastStage];
         wb_to_x_o  = trk_to_x_q[LastStage];
      end

      case (div_state_q)
         StIdle: begin
            if (div_start_o) begin
               div_state_d = StRun;
            end
         end
         StRun: begin
            if (div_done_i) begin
               if (pipe_wb) begin
                  div_state_d = StHold;
               end else begin
                  wb_valid_o   = 1'b1;
                  wb_rd_o      = div_rd_q;
                  wb_to_x_o    = div_to_x_q;
                  wb_sel_div_o = 1'b1;
                  div_state_d  = StIdle;
               end
            end
         end
         StHold: begin
            if (!pipe_wb) begin
               wb_valid_o   = 1'b1;
               wb_rd_o      = div_rd_q;
               wb_to_x_o    = div_to_x_q;
               wb_sel_div_o = 1'b1;
               div_state_d  = StIdle;
            end
         end
         default: div_state_d = StIdle;
      endcase
   end

   // Clear before set: WAW stalls guarantee the two never target the same bit.
   always_comb begin
      sb_d = sb_q;
      if (wb_valid_o && !wb_to_x_o) begin
         sb_d[wb_rd_o] = 1'b0;
      end
      if (accept && in_writes_frd_i) begin
         sb_d[in_rd_i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_state_q <= StIdle;
         sb_q        <= '0;
         trk_valid_q <= '0;
         trk_rd_q    <= '0;
         trk_to_x_q  <= '0;
         div_rd_q    <= 5'd0;
         div_to_x_q  <= 1'b0;
      end else begin
         div_state_q <= div_state_d;
         sb_q        <= sb_d;

         // Ops with no destination need no writeback slot.
         trk_valid_q[0] <= pipe_issue_o & (in_writes_frd_i | in_writes_xrd_i);
         trk_rd_q[0]    <= in_rd_i;
         trk_to_x_q[0]  <= in_writes_xrd_i;
         for (int i = 1; i < PIPE_LAT; i++) begin
            trk_valid_q[i] <= trk_valid_q[i-1];
            trk_rd_q[i]    <= trk_rd_q[i-1];
            trk_to_x_q[i]  <= trk_to_x_q[i-1];
         end

         if (div_start_o) begin
            div_rd_q   <= in_rd_i;
            div_to_x_q <= in_writes_xrd_i;
         end
      end
   end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Self-checking bench for fp_issue_ctrl (PIPE_LAT = 4). Expected writebacks
// are queued with their due cycle when stimulus is driven; a negedge monitor
// matches each DUT writeback against the entry due in that cycle.
module tb_fp_issue_ctrl;

   localparam int unsigned PIPE_LAT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] in_major;
   logic [4:0] in_rd, in_rs1, in_rs2, in_rs3;
   logic       in_u1, in_u2, in_u3;
   logic       in_wf, in_wx;
   logic       pipe_issue;
   logic       div_start;
   logic       div_done;
   logic       wb_valid;
   logic [4:0] wb_rd;
   logic       wb_to_x;
   logic       wb_sel_div;
   logic       busy;

   fp_issue_ctrl #(.PIPE_LAT(PIPE_LAT)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .in_valid_i      (in_valid),
      .in_ready_o      (in_ready),
      .in_major_i      (in_major),
      .in_rd_i         (in_rd),
      .in_rs1_i        (in_rs1),
      .in_rs2_i        (in_rs2),
      .in_rs3_i        (in_rs3),
      .in_uses_frs1_i  (in_u1),
      .in_uses_frs2_i  (in_u2),
      .in_uses_frs3_i  (in_u3),
      .in_writes_frd_i (in_wf),
      .in_writes_xrd_i (in_wx),
      .pipe_issue_o    (pipe_issue),
      .div_start_o     (div_start),
      .div_done_i      (div_done),
      .wb_valid_o      (wb_valid),
      .wb_rd_o         (wb_rd),
      .wb_to_x_o       (wb_to_x),
      .wb_sel_div_o    (wb_sel_div),
      .busy_o          (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      logic [4:0] rd;
      logic       to_x;
      logic       sel_div;
   } wb_exp_t;

   wb_exp_t exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   // Writeback scoreboard.
   always @(negedge clk) begin
      int idx;
      idx = -1;
      if (wb_valid === 1'b1) begin
         for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].due == cyc) idx = i;
         end
         n_cmp++;
         if (idx < 0) begin
            n_err++;
            $display("FAIL wb_unexpected: cycle %0d got wb rd=%0d to_x=%0b sel=%0b, required none",
                     cyc, wb_rd, wb_to_x, wb_sel_div);
         end else begin
            if ({wb_rd, wb_to_x, wb_sel_div} !==
                {exp_q[idx].rd, exp_q[idx].to_x, exp_q[idx].sel_div}) begin
               n_err++;
               $display("FAIL wb_fields: cycle %0d got rd=%0d to_x=%0b sel=%0b, required rd=%0d to_x=%0b sel=%0b",
                        cyc, wb_rd, wb_to_x, wb_sel_div,
                        exp_q[idx].rd, exp_q[idx].to_x, exp_q[idx].sel_div);
            end
            exp_q.delete(idx);
         end
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].due <= cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL wb_missing: cycle %0d got no wb, required rd=%0d due at cycle %0d",
                     cyc, exp_q[i].rd, exp_q[i].due);
            exp_q.delete(i);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wb(input int due, input logic [4:0] rd, input logic to_x,
                          input logic sel_div);
      wb_exp_t e;
      e.due = due; e.rd = rd; e.to_x = to_x; e.sel_div = sel_div;
      exp_q.push_back(e);
   endtask

   task automatic set_op(input logic [5:0] major, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rs3, input logic u1,
                         input logic u2, input logic u3, input logic wf, input logic wx);
      in_valid = 1'b1; in_major = major; in_rd = rd;
      in_rs1 = rs1; in_rs2 = rs2; in_rs3 = rs3;
      in_u1 = u1; in_u2 = u2; in_u3 = u3; in_wf = wf; in_wx = wx;
   endtask

   task automatic clr_op();
      in_valid = 1'b0; in_major = 6'd0; in_rd = 5'd0;
      in_rs1 = 5'd0; in_rs2 = 5'd0; in_rs3 = 5'd0;
      in_u1 = 1'b0; in_u2 = 1'b0; in_u3 = 1'b0; in_wf = 1'b0; in_wx = 1'b0;
   endtask

   task automatic drain(input string name);
      clr_op();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) next_cycle();
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s_drain: got pending=%0d busy=%0b, required pending=0 busy=0",
                  name, exp_q.size(), busy);
      end
      next_cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      div_done = 1'b0;
      set_op(6'd0, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if ({in_ready, pipe_issue, div_start, wb_valid, wb_rd, wb_to_x, wb_sel_div, busy} !== 12'h0)
      begin
         n_err++;
         $display("FAIL reset_outputs: got rdy=%0b iss=%0b ds=%0b wbv=%0b rd=%0d busy=%0b, required all 0",
                  in_ready, pipe_issue, div_start, wb_valid, wb_rd, busy);
      end
      next_cycle();
      rst = 1'b0;
      clr_op();
      @(negedge clk);
      n_cmp++;
      if ({in_ready, wb_valid, busy} !== 3'b100) begin
         n_err++;
         $display("FAIL reset_release: got rdy=%0b wbv=%0b busy=%0b, required 1 0 0",
                  in_ready, wb_valid, busy);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      set_op(6'd3, 5'd9, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (div_start !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_div_start: got %0b, required 1", div_start);
      end
      next_cycle();
      for (int i = 1; i <= 2; i++) begin
         set_op(6'd0, 5'(i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         @(negedge clk);
         n_cmp++;
         if (pipe_issue !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_issue%0d: got %0b, required 1", i, pipe_issue);
         end
         next_cycle();
      end
      // Two pipe ops and a div in flight: reset discards them.
      exp_q.delete();
      rst = 1'b1;
      set_op(6'd0, 5'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, pipe_issue, div_start, wb_valid, wb_rd, wb_to_x, wb_sel_div, busy} !== 12'h0)
      begin
         n_err++;
         $display("FAIL rstmid_outputs: got rdy=%0b iss=%0b ds=%0b wbv=%0b rd=%0d busy=%0b, required all 0",
                  in_ready, pipe_issue, div_start, wb_valid, wb_rd, busy);
      end
      next_cycle();
      rst = 1'b0;
      clr_op();
      div_done = 1'b1;  // late done from the discarded div lands in IDLE
      for (int i = 0; i < PIPE_LAT + 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if (wb_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_quiet: cycle %0d got wbv=%0b busy=%0b, required 0 0",
                     i, wb_valid, busy);
         end
         next_cycle();
         div_done = 1'b0;
      end
      // Scoreboard must be empty: reads f1/f9 and writes f2 without stalling.
      set_op(6'd0, 5'd2, 5'd1, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      push_wb(cyc + PIPE_LAT, 5'd2, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_sb_clear: got rdy=%0b, required 1", in_ready);
      end
      next_cycle();
      drain("rstmid");
   endtask

   task automatic test_raw();
      set_op(6'd0, 5'd5, 5'd2, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      push_wb(cyc + PIPE_LAT, 5'd5, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, pipe_issue} !== 2'b11) begin
         n_err++;
         $display("FAIL raw_first: got rdy=%0b iss=%0b, required 1 1", in_ready, pipe_issue);
      end
      next_cycle();
      // fmul f6, f5, f1 stalls T+1..T+4.
      set_op(6'd2, 5'd6, 5'd5, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= PIPE_LAT; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({in_ready, pipe_issue} !== 2'b00) begin
            n_err++;
            $display("FAIL raw_stall: T+%0d got rdy=%0b iss=%0b, required 0 0",
                     k, in_ready, pipe_issue);
         end
         next_cycle();
      end
      push_wb(cyc + PIPE_LAT, 5'd6, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, pipe_issue} !== 2'b11) begin
         n_err++;
         $display("FAIL raw_accept: got rdy=%0b iss=%0b, required 1 1", in_ready, pipe_issue);
      end
      next_cycle();
      // fmadd f7, f1, f2, f6: third source hazard on f6.
      set_op(6'd4, 5'd7, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int k = 1; k <= PIPE_LAT; k++) begin
         @(negedge clk);
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL raw_rs3_stall: step %0d got rdy=%0b, required 0", k, in_ready);
         end
         next_cycle();
      end
      push_wb(cyc + PIPE_LAT, 5'd7, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (pipe_issue !== 1'b1) begin
         n_err++;
         $display("FAIL raw_rs3_accept: got iss=%0b, required 1", pipe_issue);
      end
      next_cycle();
      drain("raw");
   endtask

   task automatic test_throughput();
      for (int i = 1; i <= 6; i++) begin
         set_op(6'd0, 5'(i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         push_wb(cyc + PIPE_LAT, 5'(i), 1'b0, 1'b0);
         @(negedge clk);
         n_cmp++;
         if ({in_ready, pipe_issue, busy} !== {2'b11, (i > 1) ? 1'b1 : 1'b0}) begin
            n_err++;
            $display("FAIL tput_issue%0d: got rdy=%0b iss=%0b busy=%0b, required 1 1 %0b",
                     i, in_ready, pipe_issue, busy, (i > 1));
         end
         next_cycle();
      end
      drain("tput");
   endtask

   task automatic test_collision();
      int t0;
      t0 = cyc;
      set_op(6'd3, 5'd10, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, div_start, pipe_issue} !== 3'b110) begin
         n_err++;
         $display("FAIL coll_div_start: got rdy=%0b ds=%0b iss=%0b, required 1 1 0",
                  in_ready, div_start, pipe_issue);
      end
      next_cycle();
      set_op(6'd0, 5'd11, 5'd3, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      push_wb(t0 + 1 + PIPE_LAT, 5'd11, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (pipe_issue !== 1'b1) begin
         n_err++;
         $display("FAIL coll_pipe_issue: got %0b, required 1", pipe_issue);
      end
      next_cycle();
      clr_op();
      while (cyc < t0 + 5) next_cycle();
      div_done = 1'b1;
      push_wb(t0 + 6, 5'd10, 1'b0, 1'b1);
      @(negedge clk);
      next_cycle();
      div_done = 1'b0;
      // f10 still pending at T+6 (cleared at the T+6 edge).
      set_op(6'd0, 5'd12, 5'd10, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, busy} !== 2'b01) begin
         n_err++;
         $display("FAIL coll_sb10_pending: got rdy=%0b busy=%0b, required 0 1", in_ready, busy);
      end
      next_cycle();
      push_wb(cyc + PIPE_LAT, 5'd12, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (pipe_issue !== 1'b1) begin
         n_err++;
         $display("FAIL coll_sb10_cleared: got iss=%0b, required 1", pipe_issue);
      end
      next_cycle();
      drain("coll");
   endtask

   task automatic test_structural();
      int t0;
      t0 = cyc;
      set_op(6'd6, 5'd20, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (div_start !== 1'b1) begin
         n_err++;
         $display("FAIL struct_sqrt1: got ds=%0b, required 1", div_start);
      end
      next_cycle();
      set_op(6'd6, 5'd21, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         if (k == 3) begin
            div_done = 1'b1;
            push_wb(cyc, 5'd20, 1'b0, 1'b1);
         end
         @(negedge clk);
         n_cmp++;
         if ({in_ready, div_start} !== 2'b00) begin
            n_err++;
            $display("FAIL struct_stall: T+%0d got rdy=%0b ds=%0b, required 0 0",
                     k, in_ready, div_start);
         end
         next_cycle();
      end
      div_done = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({in_ready, div_start} !== 2'b11) begin
         n_err++;
         $display("FAIL struct_sqrt2: got rdy=%0b ds=%0b, required 1 1", in_ready, div_start);
      end
      next_cycle();
      // Pipe ops keep issuing while the FSM is in RUN.
      set_op(6'd0, 5'd13, 5'd5, 5'd6, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      push_wb(cyc + PIPE_LAT, 5'd13, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (pipe_issue !== 1'b1) begin
         n_err++;
         $display("FAIL struct_pipe_in_run: got iss=%0b, required 1", pipe_issue);
      end
      next_cycle();
      // feq x13 with f13 pending: integer destination, no WAW stall.
      set_op(6'd9, 5'd13, 5'd7, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      push_wb(cyc + PIPE_LAT, 5'd13, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, pipe_issue} !== 2'b11) begin
         n_err++;
         $display("FAIL struct_int_dest: got rdy=%0b iss=%0b, required 1 1", in_ready, pipe_issue);
      end
      next_cycle();
      clr_op();
      while (cyc < t0 + 9) next_cycle();
      // Done collides with fadd wb, then with feq wb: result waits to T+11.
      div_done = 1'b1;
      push_wb(t0 + 11, 5'd21, 1'b0, 1'b1);
      @(negedge clk);
      next_cycle();
      div_done = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL struct_hold_busy: got busy=%0b, required 1", busy);
      end
      next_cycle();
      drain("struct");
      // div_done in IDLE is ignored.
      div_done = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({wb_valid, busy} !== 2'b00) begin
         n_err++;
         $display("FAIL struct_stray_done: got wbv=%0b busy=%0b, required 0 0", wb_valid, busy);
      end
      next_cycle();
      div_done = 1'b0;
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      div_done = 1'b0;
      clr_op();
      test_reset();
      test_reset_mid();
      test_raw();
      test_throughput();
      test_collision();
      test_structural();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
